fpu_add_sub_pipe: RTL and testbench
===================================

# fpu_add_sub_pipe

Pipelined, parametrised floating-point adder/subtractor for the FFT datapath. It replaces the single-cycle single-precision add/sub where timing closure or throughput matter. It accepts one operation per cycle through a valid/ready handshake and produces an IEEE-754-style result after a fixed 4-cycle latency. It supports any exponent/mantissa split, round-to-nearest-even with guard/round/sticky, canonical NaN, and exception flags.

## Interface
- `EXP_W`, 8, exponent width.
- `MAN_W`, 23, stored mantissa width. Word width is `W = 1+EXP_W+MAN_W`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_valid`  in  1  input operation valid.
- `o_ready`  out  1  block can accept the input this cycle.
- `i_add_sub`  in  1  operation select: 0 gives a+b, 1 gives a−b.
- `i_a`, `i_b`  in  W  operands, format {sign, exp, man}.
- `o_valid`  out  1  result valid.
- `i_ready`  in  1  downstream accepts the result.
- `o_s`  out  W  result.
- `o_flags`  out  4  {invalid, overflow, underflow, inexact}, aligned with `o_s`.

## Operation
- **S1, unpack/align:**
  - Classify each operand as zero (exp==0; subnormals are flushed to signed zero), inf, NaN or normal.
  - Effective sign of b = `b.sign ^ i_add_sub`.
  - Swap so the larger magnitude (exp, then mantissa) is first.
  - Right-shift the smaller significand {1, man, G, R, S} by d = exp difference, saturated at MAN_W+3; every bit shifted out ORs into S.
- **S2, ALU:**
  - Equal effective signs: add. Otherwise: subtract the smaller from the larger.
  - Width is MAN_W+5 (carry + hidden + man + GRS), so the result is never negative.
- **S3, normalise:**
  - Carry out: shift right 1 (old S ORs into new S), exp+1.
  - Otherwise: leading-one detect, shift left by lz, exp−lz.
  - Zero sum marks exact cancellation.
- **S4, round/pack:**
  - Round-to-nearest-even: increment when G & (R|S|lsb). A mantissa carry from rounding gives exp+1 and mantissa 0.
  - inexact = G|R|S.
- **Specials** (computed in S1, carried to S4) override the arithmetic result:
  - Any NaN input, or inf − inf (effective): `o_s` = canonical qNaN {0, all-ones, 1 followed by zeros}; invalid=1, all other flags 0.
  - Single inf, or inf with matching sign: that inf; flags 0.
  - Both zero: sign = AND of the effective signs (so −0 + −0 = −0, else +0). Exact cancellation of nonzero operands gives +0; flags 0.
  - One operand zero: the other operand, with its effective sign; flags 0.
- **Overflow** (rounded exp ≥ 2^EXP_W−1): ±inf; overflow=1, inexact=1.
- **Underflow** (normalised exp ≤ 0): signed zero; underflow=1, inexact=1.

## Timing
- Four register stages. A result appears on `o_s`/`o_valid` exactly 4 cycles after acceptance (`i_valid & o_ready`), provided there is no stall.
- Global stall: `stall = o_valid & ~i_ready`. While stalled, all stages hold their contents and `o_ready = 0`.
- `o_ready = ~stall`, combinational from `o_valid` and `i_ready`. Bubbles are not squeezed out.
- Throughput is 1 op/cycle when `i_ready` is high. Results leave in issue order; no op is lost or duplicated.
- `o_s`, `o_flags` and `o_valid` are registered and stable while `o_valid & ~i_ready`.
- Reset, including assertion mid-operation:
  - All stage valid bits, `o_valid`, `o_s` and `o_flags` clear to 0 immediately. In-flight ops are discarded.
  - `o_ready` = 1 from the first cycle after release.
- `i_a`, `i_b` and `i_add_sub` are sampled only on acceptance; other-cycle values are don't-care.

## Test plan
- **Basic add/sub:**
  - 0x3F800000 + 0x3F800000, add → 0x40000000, flags 0, `o_valid` at cycle 4.
  - Same operands, sub → 0x00000000, flags 0.
- **Round-to-nearest-even:**
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even), inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- **Specials:**
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, flags 4'b1000.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000, invalid=1.
  - 0x80000000 + 0x80000000 → 0x80000000.
- **Overflow/underflow:**
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags 4'b0101.
  - 0x00800000 − 0x00800001 → 0x80000000, flags 4'b0011.
- **Backpressure:** issue 8 back-to-back random ops, holding `i_ready` low for 3 cycles mid-stream. Outputs match the reference model in order, `o_ready` is low during the stall, no drops or duplicates. Repeat with EXP_W=5, MAN_W=10 (half precision): 0x3C00 + 0x3C00 → 0x4000.
- **Reset mid-operation:** assert `i_rst_n` low with 3 ops in flight. Outputs go to 0 asynchronously and no stale result appears after release. The first new op returns correctly 4 cycles after acceptance.

Source files
------------

// File: rtl/fpu_add_sub_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_add_sub_pipe_if
//  Purpose  : Valid/ready operand and result bundle for fpu_add_sub_pipe.
//             master = producer of operations / consumer of results,
//             slave  = the adder pipeline itself.
//  Signals  : i_valid, o_ready, i_add_sub, i_a, i_b   (operation side)
//             o_valid, i_ready, o_s, o_flags          (result side)
//  Revision : 1.0 - initial release
// ============================================================================
interface fpu_add_sub_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int c_W = 1 + EXP_W + MAN_W;

    logic           i_valid;
    logic           o_ready;
    logic           i_add_sub;
    logic [c_W-1:0] i_a;
    logic [c_W-1:0] i_b;
    logic           o_valid;
    logic           i_ready;
    logic [c_W-1:0] o_s;
    logic [3:0]     o_flags;

    modport master (
        output i_valid, i_add_sub, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_s, o_flags
    );

    modport slave (
        input  i_valid, i_add_sub, i_a, i_b, i_ready,
        output o_ready, o_valid, o_s, o_flags
    );
endinterface
`default_nettype wire

// File: rtl/fpu_add_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_add_sub_pipe
//  Purpose  : 4-stage pipelined floating-point adder/subtractor with
//             round-to-nearest-even, flush-to-zero inputs, canonical qNaN
//             and {invalid, overflow, underflow, inexact} flags.
//             S1 unpack/align, S2 add/sub, S3 normalise, S4 round/pack.
//  Ports    : i_clk   - clock, rising edge
//             i_rst_n - asynchronous active-low reset
//             bus     - fpu_add_sub_pipe_if.slave (operation + result)
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_add_sub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  wire               i_clk,
    input  wire               i_rst_n,
    fpu_add_sub_pipe_if.slave bus
);
    localparam int c_W    = 1 + EXP_W + MAN_W;
    localparam int c_SW   = MAN_W + 4;          // {hidden, man, G, R, S}
    localparam int c_EW   = EXP_W + 2;          // signed working exponent
    localparam int c_SHW  = $clog2(c_SW);
    localparam int c_DMAX = MAN_W + 3;
    localparam int c_EMAX = (1 << EXP_W) - 1;
    localparam logic [c_W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // The whole pipe freezes when the output register cannot drain.
    logic w_stall;
    assign w_stall     = bus.o_valid & ~bus.i_ready;
    assign bus.o_ready = ~w_stall;

    // ---------------------------------------------------------------- S1
    logic             w_a_s, w_b_s;
    logic [EXP_W-1:0] w_a_e, w_b_e;
    logic [MAN_W-1:0] w_a_m, w_b_m;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;

    assign w_a_s = bus.i_a[c_W-1];
    assign w_a_e = bus.i_a[c_W-2 -: EXP_W];
    assign w_a_m = bus.i_a[MAN_W-1:0];
    assign w_b_s = bus.i_b[c_W-1] ^ bus.i_add_sub;
    assign w_b_e = bus.i_b[c_W-2 -: EXP_W];
    assign w_b_m = bus.i_b[MAN_W-1:0];

    assign w_a_zero = (w_a_e == '0);
    assign w_b_zero = (w_b_e == '0);
    assign w_a_inf  = (w_a_e == '1) && (w_a_m == '0);
    assign w_b_inf  = (w_b_e == '1) && (w_b_m == '0);
    assign w_a_nan  = (w_a_e == '1) && (w_a_m != '0);
    assign w_b_nan  = (w_b_e == '1) && (w_b_m != '0);

    logic             w_a_big;
    logic             w_l_s;
    logic [EXP_W-1:0] w_l_e, w_s_e, w_d;
    logic [MAN_W-1:0] w_l_m, w_s_m;
    logic [c_SHW-1:0] w_d_sat;
    logic [c_SW-1:0]  w_l_sig, w_s_sig, w_s_align;
    logic [2*c_SW-1:0] w_ext;

    assign w_a_big = ({w_a_e, w_a_m} >= {w_b_e, w_b_m});
    assign w_l_s   = w_a_big ? w_a_s : w_b_s;
    assign w_l_e   = w_a_big ? w_a_e : w_b_e;
    assign w_l_m   = w_a_big ? w_a_m : w_b_m;
    assign w_s_e   = w_a_big ? w_b_e : w_a_e;
    assign w_s_m   = w_a_big ? w_b_m : w_a_m;
    assign w_d     = w_l_e - w_s_e;
    assign w_d_sat = (32'(w_d) > 32'(c_DMAX)) ? c_SHW'(c_DMAX) : c_SHW'(w_d);
    assign w_l_sig = {1'b1, w_l_m, 3'b000};
    assign w_s_sig = {1'b1, w_s_m, 3'b000};

    // The lower half of the widened vector collects the shifted-out bits,
    // which all collapse into the sticky position.
    assign w_ext     = {w_s_sig, {c_SW{1'b0}}} >> w_d_sat;
    assign w_s_align = {w_ext[2*c_SW-1:c_SW+1], w_ext[c_SW] | (|w_ext[c_SW-1:0])};

    logic           w_spc;
    logic [c_W-1:0] w_spc_res;
    logic [3:0]     w_spc_flg;

    always_comb begin
        w_spc     = 1'b1;
        w_spc_res = '0;
        w_spc_flg = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_s != w_b_s))) begin
            w_spc_res = c_QNAN;
            w_spc_flg = 4'b1000;
        end else if (w_a_inf) begin
            w_spc_res = {w_a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spc_res = {w_b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spc_res = {w_a_s & w_b_s, {(c_W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_spc_res = {w_b_s, w_b_e, w_b_m};
        end else if (w_b_zero) begin
            w_spc_res = bus.i_a;
        end else begin
            w_spc = 1'b0;
        end
    end

    logic             r1_valid, r1_spc, r1_sign, r1_sub;
    logic [c_W-1:0]   r1_spc_res;
    logic [3:0]       r1_spc_flg;
    logic [EXP_W-1:0] r1_exp;
    logic [c_SW-1:0]  r1_l_sig, r1_s_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r1_valid   <= 1'b0;
            r1_spc     <= 1'b0;
            r1_sign    <= 1'b0;
            r1_sub     <= 1'b0;
            r1_spc_res <= '0;
            r1_spc_flg <= 4'b0000;
            r1_exp     <= '0;
            r1_l_sig   <= '0;
            r1_s_sig   <= '0;
        end else if (!w_stall) begin
            r1_valid   <= bus.i_valid;
            r1_spc     <= w_spc;
            r1_sign    <= w_l_s;
            r1_sub     <= w_a_s ^ w_b_s;
            r1_spc_res <= w_spc_res;
            r1_spc_flg <= w_spc_flg;
            r1_exp     <= w_l_e;
            r1_l_sig   <= w_l_sig;
            r1_s_sig   <= w_s_align;
        end
    end

    // ---------------------------------------------------------------- S2
    // Larger magnitude is always on the left, so the difference is >= 0.
    logic [c_SW:0] w2_sum;
    assign w2_sum = r1_sub ? ({1'b0, r1_l_sig} - {1'b0, r1_s_sig})
                           : ({1'b0, r1_l_sig} + {1'b0, r1_s_sig});

    logic             r2_valid, r2_spc, r2_sign;
    logic [c_W-1:0]   r2_spc_res;
    logic [3:0]       r2_spc_flg;
    logic [EXP_W-1:0] r2_exp;
    logic [c_SW:0]    r2_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r2_valid   <= 1'b0;
            r2_spc     <= 1'b0;
            r2_sign    <= 1'b0;
            r2_spc_res <= '0;
            r2_spc_flg <= 4'b0000;
            r2_exp     <= '0;
            r2_sum     <= '0;
        end else if (!w_stall) begin
            r2_valid   <= r1_valid;
            r2_spc     <= r1_spc;
            r2_sign    <= r1_sign;
            r2_spc_res <= r1_spc_res;
            r2_spc_flg <= r1_spc_flg;
            r2_exp     <= r1_exp;
            r2_sum     <= w2_sum;
        end
    end

    // ---------------------------------------------------------------- S3
    logic [c_SHW-1:0]       w3_lz;
    logic [c_SW-1:0]        w3_sig;
    logic signed [c_EW-1:0] w3_exp;
    logic                   w3_cancel;

    always_comb begin
        w3_lz = '0;
        for (int i = 0; i < c_SW; i++) begin
            if (r2_sum[i]) begin
                w3_lz = c_SHW'(c_SW - 1 - i);
            end
        end
        w3_cancel = (r2_sum == '0);
        if (r2_sum[c_SW]) begin
            w3_sig = {r2_sum[c_SW:2], r2_sum[1] | r2_sum[0]};
            w3_exp = c_EW'(r2_exp) + c_EW'(1);
        end else begin
            w3_sig = r2_sum[c_SW-1:0] << w3_lz;
            w3_exp = c_EW'(r2_exp) - c_EW'(w3_lz);
        end
    end

    logic                   r3_valid, r3_spc, r3_sign, r3_cancel;
    logic [c_W-1:0]         r3_spc_res;
    logic [3:0]             r3_spc_flg;
    logic signed [c_EW-1:0] r3_exp;
    logic [c_SW-1:0]        r3_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r3_valid   <= 1'b0;
            r3_spc     <= 1'b0;
            r3_sign    <= 1'b0;
            r3_cancel  <= 1'b0;
            r3_spc_res <= '0;
            r3_spc_flg <= 4'b0000;
            r3_exp     <= '0;
            r3_sig     <= '0;
        end else if (!w_stall) begin
            r3_valid   <= r2_valid;
            r3_spc     <= r2_spc;
            r3_sign    <= r2_sign;
            r3_cancel  <= w3_cancel;
            r3_spc_res <= r2_spc_res;
            r3_spc_flg <= r2_spc_flg;
            r3_exp     <= w3_exp;
            r3_sig     <= w3_sig;
        end
    end

    // ---------------------------------------------------------------- S4
    logic                   w4_g, w4_r, w4_st, w4_inc;
    logic [MAN_W:0]         w4_man;
    logic signed [c_EW-1:0] w4_exp;
    logic [c_W-1:0]         w4_res;
    logic [3:0]             w4_flg;

    assign w4_g   = r3_sig[2];
    assign w4_r   = r3_sig[1];
    assign w4_st  = r3_sig[0];
    assign w4_inc = w4_g & (w4_r | w4_st | r3_sig[3]);
    // A rounding carry leaves the stored mantissa at zero and bumps exp.
    assign w4_man = {1'b0, r3_sig[c_SW-2:3]} + (MAN_W+1)'(w4_inc);
    assign w4_exp = r3_exp + c_EW'(w4_man[MAN_W]);

    always_comb begin
        w4_res = '0;
        w4_flg = 4'b0000;
        if (r3_spc) begin
            w4_res = r3_spc_res;
            w4_flg = r3_spc_flg;
        end else if (r3_cancel) begin
            w4_res = '0;
        end else if (r3_exp < 1) begin
            w4_res = {r3_sign, {(c_W-1){1'b0}}};
            w4_flg = 4'b0011;
        end else if (w4_exp >= c_EMAX) begin
            w4_res = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w4_flg = 4'b0101;
        end else begin
            w4_res = {r3_sign, w4_exp[EXP_W-1:0], w4_man[MAN_W-1:0]};
            w4_flg = {3'b000, w4_g | w4_r | w4_st};
        end
    end

    logic           r4_valid;
    logic [c_W-1:0] r4_s;
    logic [3:0]     r4_flags;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r4_valid <= 1'b0;
            r4_s     <= '0;
            r4_flags <= 4'b0000;
        end else if (!w_stall) begin
            r4_valid <= r3_valid;
            r4_s     <= w4_res;
            r4_flags <= w4_flg;
        end
    end

    assign bus.o_valid = r4_valid;
    assign bus.o_s     = r4_s;
    assign bus.o_flags = r4_flags;

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_sub_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_add_sub_pipe
//  Purpose  : Self-checking bench for fpu_add_sub_pipe in single and half
//             precision. Expected results come from an exact-integer
//             reference model (align, add, round by quotient/remainder).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_add_sub_pipe;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fpu_add_sub_pipe_if #(.EXP_W(8), .MAN_W(23)) sbus ();
    fpu_add_sub_pipe_if #(.EXP_W(5), .MAN_W(10)) hbus ();

    fpu_add_sub_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (.i_clk(clk), .i_rst_n(rst_n), .bus(sbus));
    fpu_add_sub_pipe #(.EXP_W(5), .MAN_W(10)) u_hp (.i_clk(clk), .i_rst_n(rst_n), .bus(hbus));

    // ------------------------------------------------------------ model
    function automatic logic [31:0] pk(input int ew, input int mw, input int s, input int e, input int m);
        return (32'(s) << (ew + mw)) | (32'(e) << mw) | 32'(m);
    endfunction

    // Returns {flags, result}.
    function automatic logic [35:0] ref_model(input bit h, input logic [31:0] a,
                                              input logic [31:0] b, input bit sub);
        int ew = h ? 5 : 8;
        int mw = h ? 10 : 23;
        int emax = (1 << ew) - 1;
        int sa = int'(a >> (ew + mw)) & 1;
        int sb = (int'(b >> (ew + mw)) & 1) ^ int'(sub);
        int ea = int'(a >> mw) & emax;
        int eb = int'(b >> mw) & emax;
        int ma = int'(a) & ((1 << mw) - 1);
        int mb = int'(b) & ((1 << mw) - 1);
        int sl, el, ml, ss, es, ms, d, p, e, sh;
        bit inexact;
        logic [127:0] x, y, sum, q, rem, half;

        if ((ea == emax && ma != 0) || (eb == emax && mb != 0) ||
            (ea == emax && eb == emax && sa != sb))
            return {4'b1000, pk(ew, mw, 0, emax, 1 << (mw - 1))};
        if (ea == emax) return {4'b0000, pk(ew, mw, sa, emax, 0)};
        if (eb == emax) return {4'b0000, pk(ew, mw, sb, emax, 0)};
        if (ea == 0 && eb == 0) return {4'b0000, pk(ew, mw, sa & sb, 0, 0)};
        if (ea == 0) return {4'b0000, pk(ew, mw, sb, eb, mb)};
        if (eb == 0) return {4'b0000, pk(ew, mw, sa, ea, ma)};

        if (ea > eb || (ea == eb && ma >= mb)) begin
            sl = sa; el = ea; ml = ma; ss = sb; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb; ss = sa; es = ea; ms = ma;
        end
        d = el - es;
        // Exact values scaled by 2^64; a far-away small operand is replaced
        // by the tiniest nonzero amount, which rounds identically.
        x = 128'((1 << mw) | ml) << 64;
        y = (d <= 64) ? (128'((1 << mw) | ms) << (64 - d)) : 128'd1;
        sum = (sl == ss) ? x + y : x - y;
        if (sum == 0) return {4'b0000, 32'h0};
        p = 0;
        for (int i = 0; i < 128; i++) if (sum[i]) p = i;
        e = el + p - (64 + mw);
        if (e <= 0) return {4'b0011, pk(ew, mw, sl, 0, 0)};
        sh = p - mw;
        inexact = 1'b0;
        if (sh > 0) begin
            q    = sum >> sh;
            rem  = sum - (q << sh);
            half = 128'd1 << (sh - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end else begin
            q = sum << (-sh);
        end
        if (q == (128'd1 << (mw + 1))) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= emax) return {4'b0101, pk(ew, mw, sl, emax, 0)};
        return {3'b000, inexact, pk(ew, mw, sl, e, int'(q[31:0]) & ((1 << mw) - 1))};
    endfunction

    function automatic logic [31:0] rand_op(input bit h);
        logic [31:0] v = $urandom;
        return h ? {16'h0, v[15:0]} : v;
    endfunction

    // Second operand biased towards a nearby exponent so results exercise
    // rounding, carries and cancellation rather than plain pass-through.
    function automatic logic [31:0] rand_near(input bit h, input logic [31:0] a);
        logic [31:0] v = rand_op(h);
        int mw = h ? 10 : 23;
        int emax = h ? 31 : 255;
        int ea = int'(a >> mw) & emax;
        int eb;
        if ($urandom_range(0, 7) == 0) begin
            v = a;
        end else if ($urandom_range(0, 3) != 0) begin
            eb = ea + int'($urandom_range(0, 8)) - 4;
            if (eb < 0) eb = 0;
            if (eb > emax) eb = emax;
            v = (v & ~(32'(emax) << mw)) | (32'(eb) << mw);
        end
        return v;
    endfunction

    // ------------------------------------------------------------ drivers
    task automatic drive(input bit h, input bit v, input logic [31:0] a,
                         input logic [31:0] b, input bit sub, input bit rdy);
        if (h) begin
            hbus.i_valid = v; hbus.i_a = a[15:0]; hbus.i_b = b[15:0];
            hbus.i_add_sub = sub; hbus.i_ready = rdy;
        end else begin
            sbus.i_valid = v; sbus.i_a = a; sbus.i_b = b;
            sbus.i_add_sub = sub; sbus.i_ready = rdy;
        end
    endtask

    task automatic sample(input bit h, output bit ov, output bit ordy,
                          output logic [31:0] s, output logic [3:0] f);
        if (h) begin
            ov = hbus.o_valid; ordy = hbus.o_ready; s = {16'h0, hbus.o_s}; f = hbus.o_flags;
        end else begin
            ov = sbus.o_valid; ordy = sbus.o_ready; s = sbus.o_s; f = sbus.o_flags;
        end
    endtask

    // Issues one op and waits (bounded) for its result; lat counts rising
    // edges from the accepting edge to the one that presents the result.
    task automatic run_op(input bit h, input logic [31:0] a, input logic [31:0] b,
                          input bit sub, output logic [31:0] res,
                          output logic [3:0] flg, output int lat);
        bit ov, ordy;
        @(negedge clk);
        drive(h, 1'b1, a, b, sub, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(h, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        lat = 1;
        sample(h, ov, ordy, res, flg);
        while (!ov && lat < 16) begin
            @(negedge clk);
            lat++;
            sample(h, ov, ordy, res, flg);
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({sbus.o_valid, sbus.o_flags, sbus.o_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_sp: got v=%b f=%b s=%h expected all zero", sbus.o_valid, sbus.o_flags, sbus.o_s);
        end
        n_tests++;
        if ({hbus.o_valid, hbus.o_flags, hbus.o_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_hp: got v=%b f=%b s=%h expected all zero", hbus.o_valid, hbus.o_flags, hbus.o_s);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sbus.o_ready !== 1'b1 || sbus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset: got ready=%b valid=%b expected 1 0", sbus.o_ready, sbus.o_valid);
        end
    endtask

    task automatic test_directed(input string name, input bit h, input logic [31:0] a,
                                 input logic [31:0] b, input bit sub,
                                 input logic [31:0] exp_s, input logic [3:0] exp_f);
        logic [31:0] s;
        logic [3:0]  f;
        int          lat;
        run_op(h, a, b, sub, s, f, lat);
        n_tests++;
        if ({f, s} !== {exp_f, exp_s} || lat != 4) begin
            n_fail++;
            $display("FAIL %s: got s=%h f=%b lat=%0d expected s=%h f=%b lat=4", name, s, f, lat, exp_s, exp_f);
        end
    endtask

    task automatic test_basic();
        test_directed("one_plus_one", 0, 32'h3F800000, 32'h3F800000, 0, 32'h40000000, 4'b0000);
        test_directed("one_minus_one", 0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 4'b0000);
    endtask

    task automatic test_rounding();
        test_directed("rne_tie_even", 0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 4'b0001);
        test_directed("rne_tie_up", 0, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 4'b0001);
    endtask

    task automatic test_specials();
        test_directed("inf_minus_inf", 0, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 4'b1000);
        test_directed("nan_input", 0, 32'h7FC00001, 32'h3F800000, 0, 32'h7FC00000, 4'b1000);
        test_directed("negzero_sum", 0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000);
        test_directed("neginf_sum", 0, 32'hFF800000, 32'hFF800000, 0, 32'hFF800000, 4'b0000);
        test_directed("zero_minus_x", 0, 32'h00000000, 32'h40400000, 1, 32'hC0400000, 4'b0000);
    endtask

    task automatic test_over_under();
        test_directed("overflow", 0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 4'b0101);
        test_directed("underflow", 0, 32'h00800000, 32'h00800001, 1, 32'h80000000, 4'b0011);
    endtask

    task automatic test_half();
        test_directed("half_one_plus_one", 1, 32'h3C00, 32'h3C00, 0, 32'h4000, 4'b0000);
    endtask

    // Streams n_ops random ops; either a fixed 3-cycle i_ready drop or a
    // random i_ready pattern. Results must match the model in issue order.
    task automatic test_stream(input string name, input bit h, input int n_ops, input bit rnd_ready);
        logic [35:0] expq[$];
        logic [35:0] want, held;
        logic [31:0] a, b, s;
        logic [3:0]  f;
        bit          sub, rdy, ov, ordy, held_v;
        int          issued, got, cyc;
        issued = 0; got = 0; cyc = 0; held_v = 1'b0; held = '0;
        a = rand_op(h); b = rand_near(h, a); sub = 1'($urandom_range(0, 1));
        while (got < n_ops && cyc < 3000) begin
            @(negedge clk);
            rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : !(cyc >= 6 && cyc <= 8);
            drive(h, issued < n_ops, a, b, sub, rdy);
            #1;
            sample(h, ov, ordy, s, f);
            if (ov && !rdy) begin
                n_tests++;
                if (ordy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_ready_in_stall: got %b expected 0 (cycle %0d)", name, ordy, cyc);
                end
                if (held_v) begin
                    n_tests++;
                    if ({f, s} !== held) begin
                        n_fail++;
                        $display("FAIL %s_hold: got %h expected %h (cycle %0d)", name, {f, s}, held, cyc);
                    end
                end
                held = {f, s};
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (ov && rdy) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra: got %h expected no result", name, {f, s});
                end else begin
                    want = expq.pop_front();
                    if ({f, s} !== want) begin
                        n_fail++;
                        $display("FAIL %s_result%0d: got f=%b s=%h expected f=%b s=%h", name, got, f, s, want[35:32], want[31:0]);
                    end
                end
                got++;
            end
            if (issued < n_ops && ordy) begin
                expq.push_back(ref_model(h, a, b, sub));
                issued++;
                a = rand_op(h); b = rand_near(h, a); sub = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        @(negedge clk);
        drive(h, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        n_tests++;
        if (got != n_ops || issued != n_ops || expq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_count: got issued=%0d received=%0d left=%0d expected %0d %0d 0",
                     name, issued, got, expq.size(), n_ops, n_ops);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] s;
        logic [3:0]  f;
        int          lat, stale;
        bit          ov, ordy;
        // three ops in consecutive cycles, then one idle cycle
        @(negedge clk); drive(0, 1, 32'h3F800000, 32'h3F800000, 0, 1);
        @(negedge clk); drive(0, 1, 32'h40000000, 32'h3F800000, 0, 1);
        @(negedge clk); drive(0, 1, 32'h40400000, 32'h3F800000, 1, 1);
        @(negedge clk); drive(0, 0, 32'h0, 32'h0, 0, 1);
        @(negedge clk);
        sample(0, ov, ordy, s, f);
        n_tests++;
        if ({ov, f, s} !== {1'b1, 4'b0000, 32'h40000000}) begin
            n_fail++;
            $display("FAIL pre_reset_result: got v=%b f=%b s=%h expected 1 0000 40000000", ov, f, s);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sbus.o_valid, sbus.o_flags, sbus.o_s} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b f=%b s=%h expected all zero", sbus.o_valid, sbus.o_flags, sbus.o_s);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_tests++;
                if (sbus.o_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ready_after_release: got %b expected 1", sbus.o_ready);
                end
            end
            if (sbus.o_valid !== 1'b0) stale++;
        end
        n_tests++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL stale_results: got %0d valid cycles expected 0", stale);
        end
        run_op(0, 32'h40400000, 32'h3F800000, 0, s, f, lat);
        n_tests++;
        if ({f, s} !== {4'b0000, 32'h40800000} || lat != 4) begin
            n_fail++;
            $display("FAIL first_after_reset: got s=%h f=%b lat=%0d expected s=40800000 f=0000 lat=4", s, f, lat);
        end
    endtask

    initial begin
        drive(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_over_under();
        test_stream("bp_sp", 0, 8, 1'b0);
        test_half();
        test_stream("bp_hp", 1, 8, 1'b0);
        test_stream("rand_sp", 0, 200, 1'b1);
        test_stream("rand_hp", 1, 200, 1'b1);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
